// File: rtl/bp_cfg_param_responder.sv
// rtl/bp_cfg_param_responder.sv - burst responder returning processor configuration fields by index

package bp_cfg_param_pkg;

    typedef enum logic [7:0] {
        e_bp_default_cfg     = 8'd0,
        e_bp_single_core_cfg = 8'd1,
        e_bp_dual_core_cfg   = 8'd2,
        e_bp_quad_core_cfg   = 8'd3
    } bp_params_e;

    typedef struct packed {
        logic [31:0] cc_x_dim;
        logic [31:0] cc_y_dim;
        logic [31:0] ic_y_dim;
        logic [31:0] mc_y_dim;
        logic [31:0] ac_x_dim;
        logic [31:0] vaddr_width;
        logic [31:0] paddr_width;
        logic [31:0] asid_width;
        logic [31:0] branch_metadata_fwd_width;
        logic [31:0] btb_tag_width;
        logic [31:0] btb_idx_width;
        logic [31:0] bht_idx_width;
        logic [31:0] ras_idx_width;
        logic [31:0] itlb_els;
        logic [31:0] dtlb_els;
        logic [31:0] lce_sets;
        logic [31:0] lce_assoc;
        logic [31:0] cce_block_width;
        logic [31:0] cce_pc_width;
        logic [31:0] l2_sets;
        logic [31:0] l2_assoc;
        logic [31:0] fe_queue_fifo_els;
        logic [31:0] fe_cmd_fifo_els;
        logic [31:0] async_coh_clk;
        logic [31:0] coh_noc_max_credits;
        logic [31:0] coh_noc_flit_width;
        logic [31:0] async_mem_clk;
        logic [31:0] mem_noc_flit_width;
        logic [31:0] async_io_clk;
        logic [31:0] io_noc_flit_width;
    } bp_proc_param_s;

    localparam bp_proc_param_s bp_single_core_cfg_p = '{
        cc_x_dim                  : 32'd1,
        cc_y_dim                  : 32'd1,
        ic_y_dim                  : 32'd1,
        mc_y_dim                  : 32'd0,
        ac_x_dim                  : 32'd0,
        vaddr_width               : 32'd39,
        paddr_width               : 32'd40,
        asid_width                : 32'd1,
        branch_metadata_fwd_width : 32'd35,
        btb_tag_width             : 32'd9,
        btb_idx_width             : 32'd6,
        bht_idx_width             : 32'd9,
        ras_idx_width             : 32'd2,
        itlb_els                  : 32'd8,
        dtlb_els                  : 32'd8,
        lce_sets                  : 32'd64,
        lce_assoc                 : 32'd8,
        cce_block_width           : 32'd512,
        cce_pc_width              : 32'd8,
        l2_sets                   : 32'd128,
        l2_assoc                  : 32'd8,
        fe_queue_fifo_els         : 32'd8,
        fe_cmd_fifo_els           : 32'd4,
        async_coh_clk             : 32'd0,
        coh_noc_max_credits       : 32'd8,
        coh_noc_flit_width        : 32'd128,
        async_mem_clk             : 32'd0,
        mem_noc_flit_width        : 32'd64,
        async_io_clk              : 32'd0,
        io_noc_flit_width         : 32'd64
    };

    // Multicore variants differ from the single-core baseline only in the core grid.
    function automatic bp_proc_param_s grid_cfg(input bp_proc_param_s base,
                                                input logic [31:0] x_dim,
                                                input logic [31:0] y_dim);
        bp_proc_param_s c;
        c          = base;
        c.cc_x_dim = x_dim;
        c.cc_y_dim = y_dim;
        return c;
    endfunction

    localparam bp_proc_param_s all_cfgs_gp [4] = '{
        bp_single_core_cfg_p,
        bp_single_core_cfg_p,
        grid_cfg(bp_single_core_cfg_p, 32'd2, 32'd1),
        grid_cfg(bp_single_core_cfg_p, 32'd2, 32'd2)
    };

endpackage

module bp_cfg_param_responder
    import bp_cfg_param_pkg::*;
#(
    parameter bp_params_e cfg_p        = e_bp_single_core_cfg,
    parameter int         data_width_p = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    req_v_i,
    output logic                    req_ready_o,
    input  logic [7:0]              req_addr_i,
    input  logic [3:0]              req_len_i,
    input  logic [3:0]              req_id_i,
    output logic                    resp_v_o,
    input  logic                    resp_yumi_i,
    output logic [data_width_p-1:0] resp_data_o,
    output logic [3:0]              resp_id_o,
    output logic                    resp_err_o,
    output logic                    resp_last_o,
    output logic [7:0]              err_count_o
);

    localparam bp_proc_param_s cfg_c = all_cfgs_gp[cfg_p];

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e      state_r;
    logic [7:0]  addr_r;
    logic [3:0]  cnt_r;
    logic [7:0]  addr_next;
    logic [64:0] first_lk;
    logic [64:0] next_lk;

    // Returns {unmapped, value} for a field index; values are zero-extended to 64 bits.
    function automatic logic [64:0] field_lookup(input logic [7:0] idx);
        logic [63:0] v;
        logic        e;
        v = '0;
        e = 1'b0;
        case (idx)
            8'd0:  v = 64'(cfg_c.cc_x_dim);
            8'd1:  v = 64'(cfg_c.cc_y_dim);
            8'd2:  v = 64'(cfg_c.ic_y_dim);
            8'd3:  v = 64'(cfg_c.mc_y_dim);
            8'd4:  v = 64'(cfg_c.ac_x_dim);
            8'd5:  v = 64'(cfg_c.vaddr_width);
            8'd6:  v = 64'(cfg_c.paddr_width);
            8'd7:  v = 64'(cfg_c.asid_width);
            8'd8:  v = 64'(cfg_c.branch_metadata_fwd_width);
            8'd9:  v = 64'(cfg_c.btb_tag_width);
            8'd10: v = 64'(cfg_c.btb_idx_width);
            8'd11: v = 64'(cfg_c.bht_idx_width);
            8'd12: v = 64'(cfg_c.ras_idx_width);
            8'd13: v = 64'(cfg_c.itlb_els);
            8'd14: v = 64'(cfg_c.dtlb_els);
            8'd15: v = 64'(cfg_c.lce_sets);
            8'd16: v = 64'(cfg_c.lce_assoc);
            8'd17: v = 64'(cfg_c.cce_block_width);
            8'd18: v = 64'(cfg_c.cce_pc_width);
            8'd19: v = 64'(cfg_c.l2_sets);
            8'd20: v = 64'(cfg_c.l2_assoc);
            8'd21: v = 64'(cfg_c.fe_queue_fifo_els);
            8'd22: v = 64'(cfg_c.fe_cmd_fifo_els);
            8'd23: v = 64'(cfg_c.async_coh_clk);
            8'd24: v = 64'(cfg_c.coh_noc_max_credits);
            8'd25: v = 64'(cfg_c.coh_noc_flit_width);
            8'd26: v = 64'(cfg_c.async_mem_clk);
            8'd27: v = 64'(cfg_c.mem_noc_flit_width);
            8'd28: v = 64'(cfg_c.async_io_clk);
            8'd29: v = 64'(cfg_c.io_noc_flit_width);
            8'h40: v = 64'(cfg_c.cc_x_dim * cfg_c.cc_y_dim);
            8'h41: v = 64'(cfg_c.cce_block_width >> 3);
            8'hFE: v = 64'(cfg_p);
            8'hFF: v = 64'h0000_0000_B9A2_C0F1;
            default: e = 1'b1;
        endcase
        return {e, v};
    endfunction

    // Lookups for the beat about to be presented: either the first beat of a new
    // burst or the successor of the current beat (address wraps mod 256).
    assign addr_next = addr_r + 8'd1;
    assign first_lk  = field_lookup(req_addr_i);
    assign next_lk   = field_lookup(addr_next);

    // Burst sequencer with registered response outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= S_IDLE;
            addr_r      <= '0;
            cnt_r       <= '0;
            req_ready_o <= 1'b0;
            resp_v_o    <= 1'b0;
            resp_data_o <= '0;
            resp_id_o   <= '0;
            resp_err_o  <= 1'b0;
            resp_last_o <= 1'b0;
            err_count_o <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_ready_o && req_v_i) begin
                        state_r     <= S_BUSY;
                        addr_r      <= req_addr_i;
                        cnt_r       <= req_len_i;
                        req_ready_o <= 1'b0;
                        resp_v_o    <= 1'b1;
                        resp_data_o <= data_width_p'(first_lk[63:0]);
                        resp_err_o  <= first_lk[64];
                        resp_id_o   <= req_id_i;
                        resp_last_o <= (req_len_i == 4'd0);
                    end else begin
                        // First edge after reset release raises ready.
                        req_ready_o <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (resp_yumi_i) begin
                        if (resp_err_o && (err_count_o != 8'hFF)) begin
                            err_count_o <= err_count_o + 8'd1;
                        end
                        if (cnt_r != 4'd0) begin
                            addr_r      <= addr_next;
                            cnt_r       <= cnt_r - 4'd1;
                            resp_data_o <= data_width_p'(next_lk[63:0]);
                            resp_err_o  <= next_lk[64];
                            resp_last_o <= (cnt_r == 4'd1);
                        end else begin
                            state_r     <= S_IDLE;
                            resp_v_o    <= 1'b0;
                            resp_last_o <= 1'b0;
                            resp_err_o  <= 1'b0;
                            req_ready_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    resp_v_o    <= 1'b0;
                    req_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bp_cfg_param_responder.md
BP_CFG_PARAM_RESPONDER -- requirements
Module: bp_cfg_param_responder

Interface
REQ-001 SHALL have parameter cfg_p, default e_bp_single_core_cfg: bp_params_e index into all_cfgs_gp; selects the reported config.
REQ-002 SHALL have parameter data_width_p, default 64: response data width.
REQ-003 SHALL have port clk_i, input, 1: sole clock.
REQ-004 SHALL have port reset_n_i, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_v_i, input, 1: burst request valid.
REQ-006 SHALL have port req_ready_o, output, 1: request accepted when req_v_i & req_ready_o.
REQ-007 SHALL have port req_addr_i, input, 8: first field index.
REQ-008 SHALL have port req_len_i, input, 4: beats minus one (1..16 beats).
REQ-009 SHALL have port req_id_i, input, 4: tag echoed on every beat.
REQ-010 SHALL have port resp_v_o, output, 1: response beat valid.
REQ-011 SHALL have port resp_yumi_i, input, 1: consumer takes beat; only legal while resp_v_o=1.
REQ-012 SHALL have port resp_data_o, output, data_width_p: field value, zero-extended.
REQ-013 SHALL have port resp_id_o, output, 4: echoed req_id_i.
REQ-014 SHALL have port resp_err_o, output, 1: field index unmapped.
REQ-015 SHALL have port resp_last_o, output, 1: final beat of burst.
REQ-016 SHALL have port err_count_o, output, 8: saturating count of consumed error beats.

Function
REQ-017 SHALL implement states IDLE and BUSY; req_ready_o=1 only in IDLE; resp_v_o=1 only in BUSY.
REQ-018 IDLE, on request handshake: SHALL latch addr, len, id into registers and enter BUSY; first beat valid the next cycle (1-cycle latency).
REQ-019 BUSY, resp_yumi_i=1 with remaining count nonzero: SHALL increment address (mod 256), decrement count, stay BUSY; next beat valid the following cycle (1 beat/cycle throughput).
REQ-020 BUSY, resp_yumi_i=1 with count zero: SHALL return to IDLE; req_ready_o=1 the next cycle (one bubble between bursts).
REQ-021 BUSY, resp_yumi_i=0: all resp_* outputs SHALL hold stable.
REQ-022 resp_last_o SHALL be 1 exactly when remaining count is zero.
REQ-023 Field map, index: value of all_cfgs_gp[cfg_p] field: 0 cc_x_dim, 1 cc_y_dim, 2 ic_y_dim, 3 mc_y_dim, 4 ac_x_dim, 5 vaddr_width, 6 paddr_width, 7 asid_width, 8 branch_metadata_fwd_width, 9 btb_tag_width, 10 btb_idx_width, 11 bht_idx_width, 12 ras_idx_width, 13 itlb_els, 14 dtlb_els, 15 lce_sets, 16 lce_assoc, 17 cce_block_width, 18 cce_pc_width, 19 l2_sets, 20 l2_assoc, 21 fe_queue_fifo_els, 22 fe_cmd_fifo_els, 23 async_coh_clk, 24 coh_noc_max_credits, 25 coh_noc_flit_width, 26 async_mem_clk, 27 mem_noc_flit_width, 28 async_io_clk, 29 io_noc_flit_width.
REQ-024 Derived fields: 0x40 SHALL return cc_x_dim*cc_y_dim; 0x41 cce_block_width/8; 0xFE cfg_p; 0xFF constant 0x0000_0000_B9A2_C0F1.
REQ-025 Any other index SHALL return data 0 with resp_err_o=1; a burst continues through unmapped indices without aborting.
REQ-026 Address wrap 0xFF->0x00 within a burst SHALL be legal and return field 0 next.
REQ-027 err_count_o SHALL increment on each yumi'd beat with resp_err_o=1, saturating at 255.
REQ-028 req_v_i while BUSY SHALL be ignored (not latched, not lost silently: requester holds).

Reset
REQ-029 While reset_n_i=0, regardless of clock: state=IDLE, resp_v_o=0, req_ready_o=0, resp_data_o=0, resp_id_o=0, resp_err_o=0, resp_last_o=0, err_count_o=0, address and count=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately; after deassertion, req_ready_o=1 on the first clock edge.

Verification
REQ-031 cfg_p=single core, req addr=0 len=0 id=5 -> next cycle resp_v_o=1, data=1, id=5, last=1, err=0.
REQ-032 single core, addr=5 len=2, yumi every cycle -> beats 39, 40, 1 on consecutive cycles; last only on third.
REQ-033 cfg_p=quad core, addr=0x40 len=1 -> data 4 then 64; cfg_p=single core -> 1 then 64.
REQ-034 addr=0xFE len=3, yumi held low 3 cycles before each beat -> beats cfg_p, 0xB9A2C0F1, 1 (wrap to field 0), 1; outputs stable while stalled; err_count_o=0.
REQ-035 addr=0x30 len=15 -> 16 beats data 0 err=1; err_count_o=16; repeat 15 more times -> err_count_o=255 saturated.
REQ-036 reset_n_i pulsed low after beat 2 of a 4-beat burst -> resp_v_o=0 asynchronously; after release req_ready_o=1, err_count_o=0, new request served normally.
